// File: rtl/oam_dma_if.sv
// oam_dma_if: control, source-memory and OAM write signals of the sprite attribute DMA
// master: the DMA engine (drives mem_req/mem_addr, oam_we/oam_addr/oam_wdata, busy, done)
// slave:  the surrounding system (drives start/src_base/count, vblank, mem_ack/mem_rdata)
interface oam_dma_if #(
    parameter int SRC_AW = 24
);
    logic              start;
    logic [SRC_AW-1:0] src_base;
    logic [7:0]        count;
    logic              vblank;
    logic              mem_req;
    logic [SRC_AW-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              oam_we;
    logic [7:0]        oam_addr;
    logic [31:0]       oam_wdata;
    logic              busy;
    logic              done;
    modport master (
        input  start, src_base, count, vblank, mem_ack, mem_rdata,
        output mem_req, mem_addr, oam_we, oam_addr, oam_wdata, busy, done
    );
    modport slave (
        output start, src_base, count, vblank, mem_ack, mem_rdata,
        input  mem_req, mem_addr, oam_we, oam_addr, oam_wdata, busy, done
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: copies attr0/attr1 word pairs from source memory into OAM, writing only during vblank
// i_vga_clk: pixel clock, all logic on posedge
// i_reset:   synchronous active-high reset, aborts any transfer
// bus:       oam_dma_if.master (start/src_base/count control, vblank, mem req/ack read port, OAM write port, busy/done)
module oam_dma #(
    parameter int NUM_SPRITES = 128,
    parameter int SRC_AW      = 24
) (
    input logic       i_vga_clk,
    input logic       i_reset,
    oam_dma_if.master bus
);
    localparam int WW = $clog2(2 * NUM_SPRITES + 1);
    typedef enum logic [2:0] {IDLE, WAIT_VB, REQ, WRITE, FINISH} state_t;
    state_t            r_state, w_next;
    logic [SRC_AW-1:0] r_base;
    logic [WW-1:0]     r_words, r_idx, w_idx_nx, w_words;
    logic [7:0]        r_oam_addr;
    logic [31:0]       r_oam_wdata;
    logic              r_done;
    assign w_words  = (32'(bus.count) > NUM_SPRITES) ? WW'(2 * NUM_SPRITES) : WW'({bus.count, 1'b0});
    assign w_idx_nx = r_idx + WW'(1);
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = (bus.count == 8'd0) ? FINISH : WAIT_VB;
            WAIT_VB: if (bus.vblank) w_next = REQ;
            REQ:     if (bus.mem_ack) w_next = WRITE;
            // A vblank drop during REQ is tolerated: the in-flight word still lands, then we park.
            WRITE:   w_next = (w_idx_nx == r_words) ? FINISH : (bus.vblank ? REQ : WAIT_VB);
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_words     <= '0;
            r_idx       <= '0;
            r_oam_addr  <= '0;
            r_oam_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            // done trails FINISH by a cycle so a zero-count start still shows one busy cycle
            r_done  <= r_state == FINISH;
            if (r_state == IDLE && bus.start) begin
                r_base  <= bus.src_base;
                r_words <= w_words;
                r_idx   <= '0;
            end
            // OAM address/data only change when a write is issued, so they hold otherwise
            if (r_state == REQ && bus.mem_ack) begin
                r_oam_addr  <= 8'(r_idx);
                r_oam_wdata <= bus.mem_rdata;
            end
            if (r_state == WRITE) r_idx <= w_idx_nx;
        end
    end
    assign bus.mem_req   = r_state == REQ;
    assign bus.mem_addr  = r_base + SRC_AW'(r_idx);
    assign bus.oam_we    = r_state == WRITE;
    assign bus.oam_addr  = r_oam_addr;
    assign bus.oam_wdata = r_oam_wdata;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_done;
endmodule
